c_shared_fifo_tracker: RTL and testbench

// - Tracks occupancy of num_queues logical FIFOs that share one physical buffer.
// - Each queue owns depth_private reserved entries. All queues compete for

---
 rtl/c_shared_fifo_tracker_pkg.sv | 22 ++
 rtl/c_shared_fifo_tracker_queue.sv | 55 +++++
 rtl/c_shared_fifo_tracker.sv | 121 ++++++++++++
 tb/tb_c_shared_fifo_tracker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/c_shared_fifo_tracker_pkg.sv
// Shared definitions for the shared-buffer FIFO occupancy tracker:
// error-bit positions and the width helper used to size the counters.
package c_shared_fifo_tracker_pkg;

  localparam int FT_ERR_UNDERFLOW = 0;
  localparam int FT_ERR_OVERFLOW  = 1;
  localparam int FT_ERR_BADSEL    = 2;

  // Bits needed to encode 'value' distinct states (0..value-1), never less than 1.
  function automatic int clogb(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/c_shared_fifo_tracker_queue.sv
// Per-queue occupancy counter with next-state encoded empty/almost_empty flags
// and the private/shared boundary indications used by the pool accounting.
module c_shared_fifo_tracker_queue
  import c_shared_fifo_tracker_pkg::*;
#(
  parameter int depth_private = 2,
  parameter int depth_shared  = 8,
  parameter int occ_width     = clogb(depth_private + depth_shared + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_active,
  input  logic                 i_push,
  input  logic                 i_pop,
  output logic [occ_width-1:0] o_occ,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  output logic                 o_uses_shared_on_push,
  output logic                 o_frees_shared_on_pop
);

  logic [occ_width-1:0] r_occ;
  logic                 r_empty;
  logic                 r_almost_empty;
  logic [occ_width-1:0] w_occ_next;

  // A simultaneous push and pop cancel; the caller has already filtered illegal ops.
  always_comb begin
    w_occ_next = r_occ;
    if (i_push && !i_pop) begin
      w_occ_next = r_occ + 1'b1;
    end else if (i_pop && !i_push) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b0;
    end else if (i_active) begin
      r_occ          <= w_occ_next;
      r_empty        <= (w_occ_next == '0);
      r_almost_empty <= (w_occ_next == occ_width'(1));
    end
  end

  assign o_occ                 = r_occ;
  assign o_empty               = r_empty;
  assign o_almost_empty        = r_almost_empty;
  assign o_uses_shared_on_push = (int'(r_occ) >= depth_private);
  assign o_frees_shared_on_pop = (int'(r_occ) > depth_private);

endmodule

// File: rtl/c_shared_fifo_tracker.sv
// Occupancy tracker for several logical FIFOs sharing one buffer: private
// entries per queue plus a common pool, with per-queue flags and error reporting.
module c_shared_fifo_tracker
  import c_shared_fifo_tracker_pkg::*;
#(
  parameter int num_queues    = 4,
  parameter int depth_private = 2,
  parameter int depth_shared  = 8,
  parameter int enable_bypass = 0,
  parameter int shared_width  = clogb(depth_shared + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    push,
  input  logic [num_queues-1:0]   push_sel,
  input  logic                    pop,
  input  logic [num_queues-1:0]   pop_sel,
  output logic [num_queues-1:0]   empty,
  output logic [num_queues-1:0]   almost_empty,
  output logic [num_queues-1:0]   full,
  output logic [num_queues-1:0]   almost_full,
  output logic [shared_width-1:0] shared_free,
  output logic [2:0]              errors
);

  localparam int OCC_W = clogb(depth_private + depth_shared + 1);

  logic [shared_width-1:0] r_shared_used;
  logic [shared_width-1:0] w_shared_next;
  logic [OCC_W-1:0]        w_occ [num_queues];
  logic [num_queues-1:0]   w_uses_shared;
  logic [num_queues-1:0]   w_frees_shared;
  logic [num_queues-1:0]   w_q_push;
  logic [num_queues-1:0]   w_q_pop;
  logic                    w_push_onehot;
  logic                    w_pop_onehot;
  logic                    w_same_q;
  logic                    w_underflow;
  logic                    w_overflow;
  logic                    w_bad_select;
  logic                    w_push_do;
  logic                    w_pop_do;
  logic                    w_shared_inc;
  logic                    w_shared_dec;
  logic                    w_pool_full;

  assign w_push_onehot = (push_sel != '0) && ((push_sel & (push_sel - 1'b1)) == '0);
  assign w_pop_onehot  = (pop_sel != '0) && ((pop_sel & (pop_sel - 1'b1)) == '0);
  assign w_same_q      = push && pop && (push_sel == pop_sel);

  // A same-queue pop frees the slot the push needs, so it never overflows.
  assign w_underflow  = pop && w_pop_onehot && ((pop_sel & empty) != '0)
                        && !((enable_bypass != 0) && w_same_q);
  assign w_overflow   = push && w_push_onehot && ((push_sel & full) != '0) && !w_same_q;
  assign w_bad_select = (push && !w_push_onehot) || (pop && !w_pop_onehot);

  assign w_push_do = push && w_push_onehot && !w_overflow;
  assign w_pop_do  = pop && w_pop_onehot && !w_underflow;

  assign errors[FT_ERR_UNDERFLOW] = w_underflow;
  assign errors[FT_ERR_OVERFLOW]  = w_overflow;
  assign errors[FT_ERR_BADSEL]    = w_bad_select;

  assign w_pool_full = (r_shared_used == shared_width'(depth_shared));
  assign shared_free = shared_width'(depth_shared) - r_shared_used;

  genvar gi;
  generate
    for (gi = 0; gi < num_queues; gi++) begin : g_queue
      assign w_q_push[gi] = w_push_do && push_sel[gi];
      assign w_q_pop[gi]  = w_pop_do && pop_sel[gi];

      c_shared_fifo_tracker_queue #(
        .depth_private (depth_private),
        .depth_shared  (depth_shared),
        .occ_width     (OCC_W)
      ) u_queue (
        .clk                   (clk),
        .reset                 (reset),
        .i_active              (active),
        .i_push                (w_q_push[gi]),
        .i_pop                 (w_q_pop[gi]),
        .o_occ                 (w_occ[gi]),
        .o_empty               (empty[gi]),
        .o_almost_empty        (almost_empty[gi]),
        .o_uses_shared_on_push (w_uses_shared[gi]),
        .o_frees_shared_on_pop (w_frees_shared[gi])
      );

      assign full[gi] = w_uses_shared[gi] && w_pool_full;
      // One slot left: either the last private entry with the pool gone, or the last pool entry.
      assign almost_full[gi] = !full[gi]
        && (((int'(w_occ[gi]) + 1 == depth_private) && w_pool_full)
            || (w_uses_shared[gi] && (shared_free == shared_width'(1))));
    end
  endgenerate

  assign w_shared_inc = w_push_do && ((push_sel & w_uses_shared) != '0);
  assign w_shared_dec = w_pop_do && ((pop_sel & w_frees_shared) != '0);

  always_comb begin
    w_shared_next = r_shared_used;
    if (!(w_push_do && w_pop_do && w_same_q)) begin
      if (w_shared_inc && !w_shared_dec) begin
        w_shared_next = r_shared_used + 1'b1;
      end else if (w_shared_dec && !w_shared_inc) begin
        w_shared_next = r_shared_used - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shared_used <= '0;
    end else if (active) begin
      r_shared_used <= w_shared_next;
    end
  end

endmodule

// File: tb/tb_c_shared_fifo_tracker.sv
// Directed bench for the shared FIFO tracker: one instance without bypass,
// one with bypass, both driven by the same stimulus.
module tb_c_shared_fifo_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic       push;
  logic [3:0] push_sel;
  logic       pop;
  logic [3:0] pop_sel;

  logic [3:0] empty0, aempty0, full0, afull0, free0;
  logic [2:0] err0;
  logic [3:0] empty1, aempty1, full1, afull1, free1;
  logic [2:0] err1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  c_shared_fifo_tracker #(
    .num_queues(4), .depth_private(2), .depth_shared(8), .enable_bypass(0)
  ) dut (
    .clk(clk), .reset(reset), .active(active),
    .push(push), .push_sel(push_sel), .pop(pop), .pop_sel(pop_sel),
    .empty(empty0), .almost_empty(aempty0), .full(full0), .almost_full(afull0),
    .shared_free(free0), .errors(err0)
  );

  c_shared_fifo_tracker #(
    .num_queues(4), .depth_private(2), .depth_shared(8), .enable_bypass(1)
  ) dut_byp (
    .clk(clk), .reset(reset), .active(active),
    .push(push), .push_sel(push_sel), .pop(pop), .pop_sel(pop_sel),
    .empty(empty1), .almost_empty(aempty1), .full(full1), .almost_full(afull1),
    .shared_free(free1), .errors(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [3:0] ps, input logic q, input logic [3:0] qs);
    push = p; push_sel = ps; pop = q; pop_sel = qs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    $display("t=%0t rst=%b act=%b push=%b/%b pop=%b/%b err=%b empty=%b full=%b free=%0d",
             $time, reset, active, push, push_sel, pop, pop_sel, err0, empty0, full0, free0);
    #1;
    push = 1'b0; pop = 1'b0; push_sel = '0; pop_sel = '0;
    #1;
  endtask

  task automatic push_q(input int q);
    drive(1'b1, 4'(1 << q), 1'b0, 4'b0000);
    tick();
  endtask

  initial begin
    reset = 1'b1; active = 1'b1;
    push = 1'b0; pop = 1'b0; push_sel = '0; pop_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_empty", empty0, 4'b1111);
    chk("rst_aempty", aempty0, 4'b0000);
    chk("rst_full", full0, 4'b0000);
    chk("rst_afull", afull0, 4'b0000);
    chk("rst_free", free0, 8);
    chk("rst_err", err0, 3'b000);
    chk("rst_byp_free", free1, 8);

    // Fill q0 through its private entries and then the whole pool
    push_q(0);
    chk("fill1_empty", empty0, 4'b1110);
    chk("fill1_aempty", aempty0, 4'b0001);
    push_q(0);
    chk("fill2_free", free0, 8);
    chk("fill2_aempty", aempty0, 4'b0000);
    for (int i = 0; i < 7; i++) push_q(0);
    chk("fill9_free", free0, 1);
    chk("fill9_afull", afull0, 4'b0001);
    push_q(0);
    chk("fill10_free", free0, 0);
    chk("fill10_full", full0, 4'b0001);
    chk("fill10_afull", afull0, 4'b0000);

    // Push to a full queue is rejected; same-queue push+pop is legal
    drive(1'b1, 4'b0001, 1'b0, 4'b0000);
    chk("ovf_err", err0, 3'b010);
    tick();
    chk("ovf_free", free0, 0);
    chk("ovf_full", full0, 4'b0001);
    drive(1'b1, 4'b0001, 1'b1, 4'b0001);
    chk("same_err", err0, 3'b000);
    tick();
    chk("same_free", free0, 0);
    chk("same_full", full0, 4'b0001);

    // q1 still has private entries while the pool is exhausted
    drive(1'b1, 4'b0010, 1'b0, 4'b0000);
    chk("q1_push_err", err0, 3'b000);
    tick();
    chk("q1_afull", afull0, 4'b0010);
    chk("q1_full", full0, 4'b0001);
    push_q(1);
    chk("q1_full2", full0, 4'b0011);

    // Reset mid-fill
    reset = 1'b1;
    drive(1'b1, 4'b0100, 1'b0, 4'b0000);
    tick();
    reset = 1'b0;
    chk("mid_rst_empty", empty0, 4'b1111);
    chk("mid_rst_full", full0, 4'b0000);
    chk("mid_rst_free", free0, 8);
    chk("mid_rst_aempty", aempty0, 4'b0000);

    // Pool contention: 5 entries each in q0 and q1 use 6 pool entries
    for (int i = 0; i < 5; i++) push_q(0);
    for (int i = 0; i < 5; i++) push_q(1);
    chk("pool_free", free0, 2);
    drive(1'b1, 4'b0100, 1'b1, 4'b0001);
    chk("pool_pp_err", err0, 3'b000);
    tick();
    chk("pool_pp_free", free0, 3);
    chk("pool_pp_aempty", aempty0, 4'b0100);
    chk("pool_pp_empty", empty0, 4'b1000);
    // Pool increment on q1 and decrement on q0 net out
    drive(1'b1, 4'b0010, 1'b1, 4'b0001);
    tick();
    chk("pool_net_free", free0, 3);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Underflow and bypass
    drive(1'b0, 4'b0000, 1'b1, 4'b1000);
    chk("udf_err", err0, 3'b001);
    chk("udf_byp_err", err1, 3'b001);
    tick();
    chk("udf_empty", empty0, 4'b1111);
    drive(1'b1, 4'b1000, 1'b1, 4'b1000);
    chk("nobyp_err", err0, 3'b001);
    chk("byp_err", err1, 3'b000);
    tick();
    chk("nobyp_empty", empty0, 4'b0111);
    chk("byp_empty", empty1, 4'b1111);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Bad select: offending op ignored, the legal one still applies
    drive(1'b1, 4'b0011, 1'b0, 4'b0000);
    chk("badsel_err", err0, 3'b100);
    tick();
    chk("badsel_empty", empty0, 4'b1111);
    chk("badsel_free", free0, 8);
    drive(1'b1, 4'b0100, 1'b1, 4'b0000);
    chk("badsel_pop_err", err0, 3'b100);
    tick();
    chk("badsel_pop_empty", empty0, 4'b1011);

    // State holds while inactive
    active = 1'b0;
    drive(1'b1, 4'b0001, 1'b0, 4'b0000);
    tick();
    active = 1'b1;
    chk("inactive_empty", empty0, 4'b1011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
